// File: rtl/ram_stream_rd.sv
// ============================================================================
// Module   : ram_stream_rd
// Brief    : Sequential RAM read engine feeding a valid/ready stream through
//            a 4-entry FIFO that absorbs the 1-cycle registered read latency.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module ram_stream_rd #(
    parameter int DATAWIDTH = 9,
    parameter int ADDRWIDTH = 9
) (
    input  logic                 clk,
    input  logic                 reset_l,
    input  logic                 start,
    input  logic [ADDRWIDTH-1:0] start_addr,
    input  logic [ADDRWIDTH:0]   len,
    output logic                 busy,
    output logic                 done,
    output logic [ADDRWIDTH-1:0] ram_addr,
    input  logic [DATAWIDTH-1:0] ram_rd_data,
    output logic [DATAWIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam logic [0:0]           c_ST_IDLE      = 1'b0;
    localparam logic [0:0]           c_ST_RUN       = 1'b1;
    localparam int                   c_FIFO_ENTRIES = 4;
    localparam logic [2:0]           c_FIFO_LIMIT   = 3'd4;
    localparam logic [ADDRWIDTH-1:0] c_ADDR_ONE     = 1;
    localparam logic [ADDRWIDTH:0]   c_CNT_ONE      = 1;
    localparam logic [ADDRWIDTH:0]   c_CNT_ZERO     = 0;

    logic [0:0]           r_state;
    logic [0:0]           w_state_next;
    logic [ADDRWIDTH-1:0] r_next_addr;
    logic [ADDRWIDTH-1:0] r_last_addr;
    logic [ADDRWIDTH:0]   r_len;
    logic [ADDRWIDTH:0]   r_issued;
    logic [ADDRWIDTH:0]   r_remaining;
    logic                 r_inflight;
    logic                 r_done;
    logic [DATAWIDTH-1:0] r_fifo [c_FIFO_ENTRIES];
    logic [1:0]           r_wr_ptr;
    logic [1:0]           r_rd_ptr;
    logic [2:0]           r_count;

    logic w_start;
    logic w_issue;
    logic w_push;
    logic w_pop;
    logic w_last_pop;

    assign out_valid  = (r_count != 3'd0);
    assign out_data   = r_fifo[r_rd_ptr];
    assign done       = r_done;
    assign w_push     = r_inflight;
    assign w_pop      = out_valid & out_ready;
    assign w_last_pop = w_pop && (r_remaining == c_CNT_ONE);
    assign w_start    = (r_state == c_ST_IDLE) && start;

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: if (start && (len != c_CNT_ZERO)) w_state_next = c_ST_RUN;
            c_ST_RUN:  if (w_last_pop) w_state_next = c_ST_IDLE;
            default:   w_state_next = c_ST_IDLE;
        endcase
    end

    // Words in flight count against FIFO space so the FIFO can never overflow.
    always_comb begin
        busy    = (r_state == c_ST_RUN);
        w_issue = (r_state == c_ST_RUN) && (r_issued < r_len) &&
                  ((r_count + {2'b00, r_inflight}) < c_FIFO_LIMIT);
        ram_addr = w_issue ? r_next_addr : r_last_addr;
    end

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            r_next_addr <= '0;
            r_last_addr <= '0;
            r_len       <= '0;
            r_issued    <= '0;
            r_remaining <= '0;
            r_inflight  <= 1'b0;
            r_done      <= 1'b0;
            r_wr_ptr    <= 2'd0;
            r_rd_ptr    <= 2'd0;
            r_count     <= 3'd0;
            for (int i = 0; i < c_FIFO_ENTRIES; i++) begin
                r_fifo[i] <= '0;
            end
        end else begin
            r_done     <= 1'b0;
            r_inflight <= w_issue;

            if (w_start) begin
                if (len == c_CNT_ZERO) begin
                    r_done <= 1'b1;
                end else begin
                    r_len       <= len;
                    r_issued    <= c_CNT_ZERO;
                    r_remaining <= len;
                    r_next_addr <= start_addr;
                end
            end

            if (w_issue) begin
                r_last_addr <= r_next_addr;
                r_next_addr <= r_next_addr + c_ADDR_ONE;
                r_issued    <= r_issued + c_CNT_ONE;
            end

            if (w_push) begin
                r_fifo[r_wr_ptr] <= ram_rd_data;
                r_wr_ptr         <= r_wr_ptr + 2'd1;
            end

            if (w_pop) begin
                r_rd_ptr    <= r_rd_ptr + 2'd1;
                r_remaining <= r_remaining - c_CNT_ONE;
                if (w_last_pop) r_done <= 1'b1;
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ram_stream_rd.sv
// ============================================================================
// Module   : tb_ram_stream_rd
// Brief    : Self-checking bench for ram_stream_rd with a queue-based model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ram_stream_rd;

    logic       clk = 1'b0;
    logic       reset_l;
    logic       start;
    logic [8:0] start_addr;
    logic [9:0] len;
    logic       busy;
    logic       done;
    logic [8:0] ram_addr;
    logic [8:0] ram_rd_data;
    logic [8:0] out_data;
    logic       out_valid;
    logic       out_ready;

    logic [8:0] mem [512];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Behavioural RAM: registered read, one cycle of latency.
    always @(posedge clk) ram_rd_data <= mem[ram_addr];

    ram_stream_rd #(.DATAWIDTH(9), .ADDRWIDTH(9)) dut (
        .clk        (clk),
        .reset_l    (reset_l),
        .start      (start),
        .start_addr (start_addr),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .ram_addr   (ram_addr),
        .ram_rd_data(ram_rd_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic latency_test(input string pfx);
        start_addr = 9'd10;
        len        = 10'd4;
        out_ready  = 1'b1;
        start      = 1'b1;
        step();
        start = 1'b0;
        check({pfx, "_c1_addr"}, 32'(ram_addr), 10);
        check({pfx, "_c1_busy"}, 32'(busy), 1);
        check({pfx, "_c1_valid"}, 32'(out_valid), 0);
        step();
        check({pfx, "_c2_addr"}, 32'(ram_addr), 11);
        check({pfx, "_c2_valid"}, 32'(out_valid), 0);
        for (int c = 3; c <= 6; c++) begin
            step();
            if (c <= 4) check({pfx, "_addr"}, 32'(ram_addr), 32'(c + 9));
            check({pfx, "_valid"}, 32'(out_valid), 1);
            check({pfx, "_data"}, 32'(out_data), 32'(c + 7));
            check({pfx, "_done_early"}, 32'(done), 0);
        end
        step();
        check({pfx, "_c7_done"}, 32'(done), 1);
        check({pfx, "_c7_busy"}, 32'(busy), 0);
        check({pfx, "_c7_valid"}, 32'(out_valid), 0);
        step();
        check({pfx, "_c8_done"}, 32'(done), 0);
    endtask

    // mode 0: always ready, 1: random ready, 2: ready low in C3..C9.
    // pulse_at > 0 fires a spurious start in that cycle of the transfer.
    task automatic xfer(input int sa, input int n, input int mode, input int pulse_at);
        logic [8:0] q[$];
        int         k;
        int         cyc;
        logic       hold;
        logic [8:0] held_data;
        for (int i = 0; i < n; i++) q.push_back(mem[(sa + i) % 512]);
        start_addr = 9'(sa);
        len        = 10'(n);
        start      = 1'b1;
        out_ready  = (mode == 0);
        step();
        start = 1'b0;
        if (n == 0) begin
            check("len0_done", 32'(done), 1);
            check("len0_busy", 32'(busy), 0);
            check("len0_valid", 32'(out_valid), 0);
            step();
            check("len0_done_clear", 32'(done), 0);
            check("len0_busy2", 32'(busy), 0);
            check("len0_valid2", 32'(out_valid), 0);
            return;
        end
        k    = 0;
        cyc  = 1;
        hold = 1'b0;
        held_data = '0;
        while (k < n && cyc < 4000) begin
            start = (cyc == pulse_at);
            if (start) begin
                start_addr = 9'($urandom);
                len        = 10'($urandom_range(1, 300));
            end
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom);
                default: out_ready = !(cyc >= 3 && cyc <= 9);
            endcase
            check("busy_run", 32'(busy), 1);
            check("done_run", 32'(done), 0);
            if (hold) check("stable", 32'(out_data), 32'(held_data));
            if (mode == 0 && cyc <= n && cyc <= 4)
                check("addr_seq", 32'(ram_addr), 32'((sa + cyc - 1) % 512));
            if (mode == 2 && cyc >= 5 && cyc <= 9) begin
                check("bp_addr_held", 32'(ram_addr), 32'((sa + 3) % 512));
                check("bp_valid", 32'(out_valid), 1);
                check("bp_data", 32'(out_data), 32'(q[0]));
            end
            if (out_valid && out_ready) begin
                check("data", 32'(out_data), 32'(q[k]));
                k++;
            end
            hold      = out_valid && !out_ready;
            held_data = out_data;
            step();
            cyc++;
        end
        start = 1'b0;
        check("word_count", 32'(k), 32'(n));
        check("done_pulse", 32'(done), 1);
        check("busy_end", 32'(busy), 0);
        check("valid_end", 32'(out_valid), 0);
        step();
        check("done_clear", 32'(done), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 9'(i);
        reset_l    = 1'b0;
        start      = 1'b0;
        start_addr = '0;
        len        = '0;
        out_ready  = 1'b0;
        step();
        step();
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_addr", 32'(ram_addr), 0);
        check("rst_data", 32'(out_data), 0);
        reset_l = 1'b1;
        step();

        latency_test("t1");
        xfer(0, 8, 2, 0);
        xfer(510, 4, 0, 0);
        xfer(77, 0, 0, 0);
        xfer(0, 512, 0, 0);
        xfer(100, 20, 0, 5);
        xfer(300, 15, 1, 7);

        // Abort after two of six words have been delivered.
        start_addr = 9'd20;
        len        = 10'd6;
        out_ready  = 1'b1;
        start      = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check("abort_w0", 32'(out_data), 20);
        step();
        check("abort_w1", 32'(out_data), 21);
        step();
        reset_l = 1'b0;
        step();
        reset_l = 1'b1;
        check("abort_busy", 32'(busy), 0);
        check("abort_valid", 32'(out_valid), 0);
        check("abort_done", 32'(done), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("abort_no_done", 32'(done), 0);
            check("abort_no_valid", 32'(out_valid), 0);
        end
        latency_test("t6");

        for (int i = 0; i < 512; i++) mem[i] = 9'($urandom);
        for (int r = 0; r < 8; r++) begin
            xfer(int'($urandom_range(0, 511)), int'($urandom_range(1, 64)), 1,
                 int'($urandom_range(0, 10)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ram_stream_rd.md
Name: ram_stream_rd

Overview:
Read-side streaming engine for a dual-address inferred RAM port. On a start command it issues sequential read addresses to one RAM port, absorbs the RAM's 1-cycle registered read latency, and presents the words on a valid/ready output stream with full backpressure support. It is the consumer/reader counterpart to a block that fills the RAM through the other port, for example a packet or line buffer.

Parameters:
DATAWIDTH, 9, RAM word width.
ADDRWIDTH, 9, RAM address width. RAM depth is 2^ADDRWIDTH.

Ports:
clk  in  1  single clock; all logic rising-edge.
reset_l  in  1  synchronous active-low reset.
start  in  1  command strobe; sampled only when busy=0.
start_addr  in  ADDRWIDTH  first word address.
len  in  ADDRWIDTH+1  word count, 0..2^ADDRWIDTH.
busy  out  1  transfer in progress.
done  out  1  one-cycle pulse at transfer completion.
ram_addr  out  ADDRWIDTH  read address to RAM port (its we is tied low at integration).
ram_rd_data  in  DATAWIDTH  RAM registered read data.
out_data  out  DATAWIDTH  stream data.
out_valid  out  1  stream valid.
out_ready  in  1  stream ready from sink.

Behaviour:
- Reset (reset_l=0 at an edge): busy=0, done=0, out_valid=0, ram_addr=0, out_data=0. Issue counter, remaining count, in-flight flag and output buffer are cleared. A reset mid-transfer aborts the transfer, discards buffered and in-flight words, and produces no done pulse.
- RAM timing contract: an address on ram_addr in cycle N returns that word on ram_rd_data in cycle N+1.
- States:
  - IDLE: start=1 with len>0 at the edge moves to RUN; busy=1 from the next cycle.
  - start=1 with len=0 stays in IDLE; done=1 in the next cycle; busy stays 0.
  - start while busy=1 is ignored.
- RUN:
  - Internal 4-entry output FIFO.
  - A read is issued in a cycle when issued<len and (fifo_count + inflight) < 4.
  - On issue, ram_addr holds the current address, and the address increments modulo 2^ADDRWIDTH (wraps from 2^ADDRWIDTH-1 to 0).
  - When a read was issued in the previous cycle, ram_rd_data is pushed into the FIFO at the end of the current cycle.
  - When no read is issued, ram_addr holds its last value.
- Output: out_valid=1 whenever the FIFO is non-empty; out_data is the FIFO head. A word pops on out_valid & out_ready. A push and a pop in the same cycle are both honoured and the count is unchanged.
- Throughput: with out_ready held at 1, one word per cycle.
- Latency: start in cycle C0; first issue in C1 with ram_addr=start_addr; first out_valid=1 in C3.
- Completion: when the final (len-th) word handshakes in cycle K, done=1 and busy=0 in K+1, and the block returns to IDLE. A new start is accepted in K+1.
- Stability: out_data must not change while out_valid=1 and out_ready=0.
- Overflow: the FIFO never overflows; the issue rule guarantees it.
- Arithmetic: issued and remaining counters are ADDRWIDTH+1 bits wide, so len=2^ADDRWIDTH reads each location exactly once.

Test Plan:
1. ADDRWIDTH=9; RAM preloaded with mem[i]=i. Start start_addr=10, len=4, out_ready=1 -> ram_addr 10,11,12,13 in C1..C4; out_valid in C3..C6 with data 10,11,12,13; done pulse in C7; busy=0 from C7.
2. Backpressure: len=8, out_ready=0 for cycles C3..C9, then 1 -> exactly 4 reads issued before stall; out_data stays 0 while stalled; then 0..7 delivered in order with no loss or duplication; done one cycle after the 8th handshake.
3. Wrap: start_addr=510, len=4 -> ram_addr sequence 510,511,0,1; data mem[510],mem[511],mem[0],mem[1].
4. len=0 -> done=1 in C1; busy never asserts; out_valid never asserts. len=512 -> 512 words covering every address once; done after the last handshake.
5. Start pulsed mid-transfer with different start_addr and len -> ignored; original stream completes unchanged.
6. reset_l=0 for one cycle after 2 of 6 words are delivered -> next cycle busy=0, out_valid=0, no done pulse; a fresh start then behaves exactly as in test 1.
